// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, ALUop
// encodings, datapath select encodings, the control FSM state enum and the
// bundle of datapath control signals.
package cpu_ctrl_pkg;

    // Instruction opcodes (4-bit base encoding)
    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ALUop encodings consumed by the ALU control decoder (2'b11 is reserved)
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control FSM states; the encoding is visible on the State debug port
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_WB_R      = 4'd4,
        S_EXEC_I    = 4'd5,
        S_WB_I      = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    // All datapath controls driven by the FSM, grouped for a single default
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       illegal_op;
    } ctl_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU. Sequences fetch, decode, execute,
// memory and writeback over the shared ALU, register file and single memory
// port. Outputs are Moore-decoded from the state, except that the FETCH
// IR/PC load is gated by MemReady so it fires once, on the acknowledge cycle.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W        = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUop,
    output logic [1:0]          PCSource,
    output logic                Halted,
    output logic                IllegalOp,
    output logic [3:0]          State
);

    state_t state;
    state_t state_next;
    ctl_t   ctl;
    logic   op_legal;

    // Zero is gated in the datapath by PCWriteCond; the FSM itself never branches on it.
    logic unused_zero;
    assign unused_zero = Zero;

    // Recognise the opcodes this control path knows how to sequence
    always_comb begin
        op_legal = 1'b0;
        case (Opcode)
            OPCODE_W'(OP_R),
            OPCODE_W'(OP_LW),
            OPCODE_W'(OP_SW),
            OPCODE_W'(OP_BEQ),
            OPCODE_W'(OP_ADDI),
            OPCODE_W'(OP_J),
            OPCODE_W'(OP_HALT): op_legal = 1'b1;
            default:            op_legal = 1'b0;
        endcase
    end

    // State register; reset aborts any instruction, including a memory wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; Opcode is only looked at in DECODE and MEM_ADDR
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      state_next = S_FETCH;
            S_FETCH:     state_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OPCODE_W'(OP_R):    state_next = S_EXEC_R;
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):   state_next = S_MEM_ADDR;
                    OPCODE_W'(OP_BEQ):  state_next = S_BRANCH;
                    OPCODE_W'(OP_ADDI): state_next = S_EXEC_I;
                    OPCODE_W'(OP_J):    state_next = S_JUMP;
                    OPCODE_W'(OP_HALT): state_next = S_HALT;
                    default:            state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_EXEC_R:    state_next = S_WB_R;
            S_WB_R:      state_next = S_FETCH;
            S_EXEC_I:    state_next = S_WB_I;
            S_WB_I:      state_next = S_FETCH;
            S_MEM_ADDR:  state_next = (Opcode == OPCODE_W'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next = MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = MemReady ? S_FETCH : S_MEM_WRITE;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // Output decode from state; anything not named for a state stays 0
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.i_or_d    = 1'b0;
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_ONE;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = MemReady;
                ctl.pc_write  = MemReady;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (imm << shift)
                ctl.alu_src_a  = 1'b0;
                ctl.alu_src_b  = SRCB_SHIMM;
                ctl.alu_op     = ALUOP_ADD;
                ctl.illegal_op = ~op_legal;
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALUOP_FUNC;
            end
            S_WB_R: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.mem_to_reg = 1'b0;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_WB_I: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b0;
                ctl.mem_to_reg = 1'b0;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.reg_dst    = 1'b0;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_REG;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            S_HALT: begin
                ctl.halted = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign IorD        = ctl.i_or_d;
    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign IRWrite     = ctl.ir_write;
    assign MemtoReg    = ctl.mem_to_reg;
    assign RegWrite    = ctl.reg_write;
    assign RegDst      = ctl.reg_dst;
    assign ALUSrcA     = ctl.alu_src_a;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUop       = ctl.alu_op;
    assign PCSource    = ctl.pc_source;
    assign Halted      = ctl.halted;
    assign IllegalOp   = ctl.illegal_op;
    assign State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Two instances share all inputs:
// u_dut refetches on an illegal opcode, u_dut_h halts on one.
module tb_multicycle_control;
    import cpu_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] Opcode;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA, Halted, IllegalOp;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] State;

    logic       PCWrite_h, PCWriteCond_h, IorD_h, MemRead_h, MemWrite_h, IRWrite_h;
    logic       MemtoReg_h, RegWrite_h, RegDst_h, ALUSrcA_h, Halted_h, IllegalOp_h;
    logic [1:0] ALUSrcB_h, ALUop_h, PCSource_h;
    logic [3:0] State_h;

    int tests  = 0;
    int fails  = 0;
    int cycles = 0;
    int cyc0   = 0;

    // Control vector layout:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite}_{MemtoReg,RegWrite,RegDst,ALUSrcA}
    // _{ALUSrcB}_{ALUop}_{PCSource}_{Halted,IllegalOp}
    localparam logic [17:0] C_IDLE       = 18'b000000_0000_00_00_00_00;
    localparam logic [17:0] C_FETCH_RDY  = 18'b100101_0000_01_00_00_00;
    localparam logic [17:0] C_FETCH_WAIT = 18'b000100_0000_01_00_00_00;
    localparam logic [17:0] C_DECODE     = 18'b000000_0000_11_00_00_00;
    localparam logic [17:0] C_DECODE_ILL = 18'b000000_0000_11_00_00_01;
    localparam logic [17:0] C_EXEC_R     = 18'b000000_0001_00_10_00_00;
    localparam logic [17:0] C_WB_R       = 18'b000000_0110_00_00_00_00;
    localparam logic [17:0] C_EXEC_I     = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] C_WB_I       = 18'b000000_0100_00_00_00_00;
    localparam logic [17:0] C_MEM_ADDR   = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] C_MEM_READ   = 18'b001100_0000_00_00_00_00;
    localparam logic [17:0] C_MEM_WB     = 18'b000000_1100_00_00_00_00;
    localparam logic [17:0] C_MEM_WRITE  = 18'b001010_0000_00_00_00_00;
    localparam logic [17:0] C_BRANCH     = 18'b010000_0001_00_01_01_00;
    localparam logic [17:0] C_JUMP       = 18'b100000_0000_00_00_10_00;
    localparam logic [17:0] C_HALT       = 18'b000000_0000_00_00_00_10;

    logic [17:0] ctl0;
    logic [17:0] ctl_h;
    assign ctl0  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUop, PCSource,
                    Halted, IllegalOp};
    assign ctl_h = {PCWrite_h, PCWriteCond_h, IorD_h, MemRead_h, MemWrite_h, IRWrite_h,
                    MemtoReg_h, RegWrite_h, RegDst_h, ALUSrcA_h, ALUSrcB_h, ALUop_h,
                    PCSource_h, Halted_h, IllegalOp_h};

    multicycle_control #(.OPCODE_W(4), .HALT_ON_ILLEGAL(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .Halted(Halted), .IllegalOp(IllegalOp), .State(State)
    );

    multicycle_control #(.OPCODE_W(4), .HALT_ON_ILLEGAL(1'b1)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite_h), .PCWriteCond(PCWriteCond_h), .IorD(IorD_h), .MemRead(MemRead_h),
        .MemWrite(MemWrite_h), .IRWrite(IRWrite_h), .MemtoReg(MemtoReg_h), .RegWrite(RegWrite_h),
        .RegDst(RegDst_h), .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h), .ALUop(ALUop_h),
        .PCSource(PCSource_h), .Halted(Halted_h), .IllegalOp(IllegalOp_h), .State(State_h)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check u_dut state and controls for the current cycle, then advance one clock
    task automatic step(input string tag, input state_t st, input logic [17:0] ctl);
        #1;
        chk({tag, "/state"}, 32'(State), 32'(st));
        chk({tag, "/ctl"}, 32'(ctl0), 32'(ctl));
        @(posedge clk);
        #1;
        cycles++;
    endtask

    initial begin
        rst_n    = 1'b0;
        Opcode   = 4'b0000;
        Zero     = 1'b0;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_h/state", 32'(State_h), 32'(S_IDLE));
        chk("rst_h/ctl", 32'(ctl_h), 32'(C_IDLE));
        step("rst", S_IDLE, C_IDLE);
        rst_n = 1'b1;
        step("idle", S_IDLE, C_IDLE);

        // R-type, memory ready; Opcode changes in EXEC_R must be ignored
        step("r_fetch", S_FETCH, C_FETCH_RDY);
        step("r_dec", S_DECODE, C_DECODE);
        Opcode = 4'b0101;
        step("r_exec", S_EXEC_R, C_EXEC_R);
        step("r_wb", S_WB_R, C_WB_R);

        // LW with 3 fetch waits and 2 read waits: 10 cycles
        cyc0 = cycles;
        Opcode   = 4'b0001;
        MemReady = 1'b0;
        repeat (3) step("lw_fwait", S_FETCH, C_FETCH_WAIT);
        MemReady = 1'b1;
        step("lw_fetch", S_FETCH, C_FETCH_RDY);
        MemReady = 1'b0;
        step("lw_dec", S_DECODE, C_DECODE);
        step("lw_addr", S_MEM_ADDR, C_MEM_ADDR);
        repeat (2) step("lw_mwait", S_MEM_READ, C_MEM_READ);
        MemReady = 1'b1;
        step("lw_mrd", S_MEM_READ, C_MEM_READ);
        step("lw_wb", S_MEM_WB, C_MEM_WB);
        chk("lw_cycles", 32'(cycles - cyc0), 32'd10);

        // SW, memory ready: 4 cycles
        cyc0 = cycles;
        Opcode = 4'b0010;
        step("sw_fetch", S_FETCH, C_FETCH_RDY);
        step("sw_dec", S_DECODE, C_DECODE);
        step("sw_addr", S_MEM_ADDR, C_MEM_ADDR);
        step("sw_mem", S_MEM_WRITE, C_MEM_WRITE);
        chk("sw_cycles", 32'(cycles - cyc0), 32'd4);

        // BEQ with Zero low, then Zero high: PCWrite stays 0 in BRANCH
        cyc0 = cycles;
        Opcode = 4'b0011;
        Zero   = 1'b0;
        step("beq0_fetch", S_FETCH, C_FETCH_RDY);
        step("beq0_dec", S_DECODE, C_DECODE);
        step("beq0_br", S_BRANCH, C_BRANCH);
        chk("beq_cycles", 32'(cycles - cyc0), 32'd3);
        Zero = 1'b1;
        step("beq1_fetch", S_FETCH, C_FETCH_RDY);
        step("beq1_dec", S_DECODE, C_DECODE);
        step("beq1_br", S_BRANCH, C_BRANCH);
        Zero = 1'b0;

        // J
        Opcode = 4'b0101;
        step("j_fetch", S_FETCH, C_FETCH_RDY);
        step("j_dec", S_DECODE, C_DECODE);
        step("j_jump", S_JUMP, C_JUMP);

        // ADDI
        Opcode = 4'b0100;
        step("addi_fetch", S_FETCH, C_FETCH_RDY);
        step("addi_dec", S_DECODE, C_DECODE);
        step("addi_exec", S_EXEC_I, C_EXEC_I);
        step("addi_wb", S_WB_I, C_WB_I);

        // Illegal opcode: u_dut refetches, u_dut_h halts
        Opcode = 4'b1010;
        step("ill_fetch", S_FETCH, C_FETCH_RDY);
        #1;
        chk("ill_h/state", 32'(State_h), 32'(S_DECODE));
        chk("ill_h/ctl", 32'(ctl_h), 32'(C_DECODE_ILL));
        step("ill_dec", S_DECODE, C_DECODE_ILL);
        #1;
        chk("ill_h_halt/state", 32'(State_h), 32'(S_HALT));
        chk("ill_h_halt/ctl", 32'(ctl_h), 32'(C_HALT));
        step("ill_refetch", S_FETCH, C_FETCH_RDY);

        // HALT is absorbing regardless of inputs
        for (int i = 0; i < 20; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            Opcode   = 4'($urandom_range(0, 15));
            #1;
            chk("halt_hold/state", 32'(State_h), 32'(S_HALT));
            chk("halt_hold/halted", 32'(Halted_h), 32'd1);
            @(posedge clk);
            #1;
        end

        // Reset both instances, then abort a SW mid memory wait
        rst_n = 1'b0;
        #1;
        chk("rst2_h/state", 32'(State_h), 32'(S_IDLE));
        chk("rst2/state", 32'(State), 32'(S_IDLE));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        Opcode   = 4'b0010;
        MemReady = 1'b1;
        step("rst2_idle", S_IDLE, C_IDLE);
        step("sww_fetch", S_FETCH, C_FETCH_RDY);
        step("sww_dec", S_DECODE, C_DECODE);
        MemReady = 1'b0;
        step("sww_addr", S_MEM_ADDR, C_MEM_ADDR);
        step("sww_wait", S_MEM_WRITE, C_MEM_WRITE);
        #1;
        chk("sww_pre/memwrite", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort/memwrite", 32'(MemWrite), 32'd0);
        chk("abort/state", 32'(State), 32'(S_IDLE));
        chk("abort/ctl", 32'(ctl0), 32'(C_IDLE));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        MemReady = 1'b1;
        step("rel_idle", S_IDLE, C_IDLE);
        step("rel_fetch", S_FETCH, C_FETCH_RDY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
